// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP accelerator weight store: default geometry
// and the encoding of the post-reset clear state machine.
package mlp_pkg;

    localparam int MLP_ADDR_WIDTH = 6;
    localparam int MLP_DATA_WIDTH = 16;
    localparam int MLP_NUM_BANKS  = 4;

    typedef logic [0:0] clr_state_t;

    localparam clr_state_t ST_CLEAR = 1'b0;
    localparam clr_state_t ST_IDLE  = 1'b1;

    // A single bank still needs a one-bit bank field so port widths stay legal.
    function automatic int bankWidth(input int numBanks);
        return (numBanks > 1) ? $clog2(numBanks) : 1;
    endfunction

endpackage

// File: rtl/mlp_weight_ram.sv
// One weight bank: synchronous write port plus a registered read port, shaped
// so the memory array maps onto a block RAM.
module mlp_weight_ram #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    (* ramstyle = "M9K" *) logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking update gives read-before-write when both hit one address.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mlp_weight_bank.sv
// Multi-bank weight store: clears every bank after reset, accepts an
// auto-incrementing host write stream and serves parallel registered reads.
module mlp_weight_bank
    import mlp_pkg::*;
#(
    parameter int ADDR_WIDTH = MLP_ADDR_WIDTH,
    parameter int DATA_WIDTH = MLP_DATA_WIDTH,
    parameter int NUM_BANKS  = MLP_NUM_BANKS,
    localparam int BANK_WIDTH = bankWidth(NUM_BANKS)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_ld_start,
    input  logic [BANK_WIDTH-1:0]           i_ld_bank,
    input  logic [ADDR_WIDTH-1:0]           i_ld_addr,
    input  logic                            i_ld_valid,
    input  logic [DATA_WIDTH-1:0]           i_ld_data,
    output logic                            o_ld_ready,
    output logic                            o_ld_wrap,
    input  logic                            i_rd_en,
    input  logic [ADDR_WIDTH-1:0]           i_rd_addr,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] o_rd_data,
    output logic                            o_rd_valid,
    output logic                            o_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BANK_WIDTH-1:0] LAST_BANK = BANK_WIDTH'(NUM_BANKS - 1);

    clr_state_t              r_state;
    logic [ADDR_WIDTH-1:0]   r_clrCnt;
    logic [BANK_WIDTH-1:0]   r_ptrBank;
    logic [ADDR_WIDTH-1:0]   r_ptrAddr;
    logic                    r_ldWrap;
    logic                    r_rdValid;

    logic                    w_idle;
    logic                    w_clearing;
    logic                    w_wrAccept;
    logic                    w_rdAccept;
    logic                    w_wrap;
    logic [BANK_WIDTH-1:0]   w_baseBank;
    logic [ADDR_WIDTH-1:0]   w_baseAddr;
    logic [BANK_WIDTH-1:0]   w_nextBank;
    logic [ADDR_WIDTH-1:0]   w_nextAddr;
    logic [ADDR_WIDTH-1:0]   w_ramWaddr;
    logic [DATA_WIDTH-1:0]   w_ramWdata;
    logic [NUM_BANKS-1:0]    w_ramWe;

    assign w_idle     = (r_state == ST_IDLE) && !i_rst;
    assign w_clearing = (r_state == ST_CLEAR) && !i_rst;
    assign w_wrAccept = w_idle && i_ld_valid;
    assign w_rdAccept = w_idle && i_rd_en;

    // A start in the same cycle as a write redirects that write to the new base.
    always_comb begin
        w_baseBank = i_ld_start ? i_ld_bank : r_ptrBank;
        w_baseAddr = i_ld_start ? i_ld_addr : r_ptrAddr;
        w_wrap     = (w_baseBank == LAST_BANK) && (w_baseAddr == LAST_ADDR);
        w_nextAddr = w_baseAddr + ADDR_WIDTH'(1);
        w_nextBank = w_baseBank;
        if (w_baseAddr == LAST_ADDR) begin
            w_nextBank = (w_baseBank == LAST_BANK) ? '0 : w_baseBank + BANK_WIDTH'(1);
        end
    end

    always_comb begin
        w_ramWaddr = w_clearing ? r_clrCnt : w_baseAddr;
        w_ramWdata = w_clearing ? '0 : i_ld_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_CLEAR;
            r_clrCnt <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_clrCnt <= r_clrCnt + ADDR_WIDTH'(1);
            if (r_clrCnt == LAST_ADDR) begin
                r_state <= ST_IDLE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptrBank <= '0;
            r_ptrAddr <= '0;
        end else if (w_wrAccept) begin
            r_ptrBank <= w_nextBank;
            r_ptrAddr <= w_nextAddr;
        end else if (w_idle && i_ld_start) begin
            r_ptrBank <= i_ld_bank;
            r_ptrAddr <= i_ld_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ldWrap  <= 1'b0;
            r_rdValid <= 1'b0;
        end else begin
            r_ldWrap  <= w_wrAccept && w_wrap;
            r_rdValid <= w_rdAccept;
        end
    end

    genvar b;
    generate
        for (b = 0; b < NUM_BANKS; b++) begin : g_bank
            assign w_ramWe[b] = w_clearing || (w_wrAccept && (w_baseBank == BANK_WIDTH'(b)));

            mlp_weight_ram #(
                .ADDR_WIDTH (ADDR_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_ram (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_we    (w_ramWe[b]),
                .i_waddr (w_ramWaddr),
                .i_wdata (w_ramWdata),
                .i_re    (w_rdAccept),
                .i_raddr (i_rd_addr),
                .o_rdata (o_rd_data[b*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign o_busy     = (r_state == ST_CLEAR);
    assign o_ld_ready = !o_busy;
    assign o_ld_wrap  = r_ldWrap;
    assign o_rd_valid = r_rdValid;

endmodule

// File: doc/mlp_weight_bank.md
# mlp_weight_bank

Multi-bank weight store for the MLP accelerator. It holds one weight bank per parallel perceptron lane and self-clears all banks after reset. The host loads weights as an auto-incrementing stream, and all lanes read the same weight index in parallel through a registered (M9K-friendly) read port. It sits between the host/loader interface and the MAC lanes, and replaces the single-bank, combinational-read weight memory.

## Interface
- ADDR_WIDTH, 6, log2 of words per bank (DEPTH = 2^ADDR_WIDTH)
- DATA_WIDTH, 16, weight width (fixed-point)
- NUM_BANKS, 4, number of banks/lanes (power of two, ≥1)
- BANK_WIDTH, derived, max(1, clog2(NUM_BANKS)) (localparam)
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ld_start  in  1  pulse: load stream pointer from ld_bank/ld_addr
- ld_bank  in  BANK_WIDTH  stream start bank
- ld_addr  in  ADDR_WIDTH  stream start address
- ld_valid  in  1  write ld_data at current pointer
- ld_data  in  DATA_WIDTH  weight to write
- ld_ready  out  1  1 when writes are accepted (not clearing)
- ld_wrap  out  1  one-cycle pulse when the pointer wraps from the last bank/last address to 0/0
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  index read from every bank
- rd_data  out  NUM_BANKS*DATA_WIDTH  bank b occupies bits [b*DATA_WIDTH +: DATA_WIDTH]
- rd_valid  out  1  rd_data holds the result of an accepted read
- busy  out  1  clear sequence in progress

## Operation
- FSM has two states: CLEAR and IDLE.
  - rst forces CLEAR and sets clr_cnt = 0.
  - In CLEAR, each cycle writes 0 to address clr_cnt in all banks, then increments clr_cnt.
  - CLEAR goes to IDLE after the write at DEPTH-1.
- busy = (state == CLEAR). ld_ready = !busy.
- In CLEAR:
  - ld_start and ld_valid are ignored.
  - rd_en is dropped (no rd_valid).
- Stream pointer {ptr_bank, ptr_addr}:
  - ld_start loads it from ld_bank/ld_addr.
  - Each accepted ld_valid writes ld_data to bank ptr_bank at ptr_addr, then increments the pointer.
  - The address wraps DEPTH-1 → 0 and carries into the bank field.
  - Bank NUM_BANKS-1, address DEPTH-1 wraps to 0/0 and asserts ld_wrap the next cycle.
- ld_start and ld_valid in the same cycle: the write goes to the new base (ld_bank/ld_addr), and the pointer becomes base+1.
- Pointer reset value is 0/0. A stream may start without ld_start.
- Read:
  - An accepted rd_en registers all banks at rd_addr.
  - rd_data and rd_valid update on the next edge.
  - When rd_en = 0, rd_valid = 0 and rd_data holds its last value.
- Read and write to the same bank/address in the same cycle returns the old data (read-before-write).

## Timing
- Reset values: busy=1, ld_ready=0, ld_wrap=0, rd_valid=0, rd_data=0.
- Clear duration: the first edge with rst low performs the address-0 clear. busy falls exactly DEPTH edges after rst deasserts (64 cycles by default).
- rst asserted mid-clear or mid-stream restarts the clear from address 0 and resets the pointer.
- Write latency: data is visible to a read issued on the cycle after the write edge.
- Read latency: 1 cycle (rd_en at edge N → rd_valid/rd_data after edge N+1). Full throughput, one read per cycle.
- ld_wrap is a single-cycle pulse in the cycle after the wrapping write.
- Reads and writes are independent ports and may occur every cycle concurrently.

## Structure
- Shared package `mlp_pkg`: default ADDR_WIDTH/DATA_WIDTH/NUM_BANKS and FSM state encoding (CLEAR, IDLE).
- Sub-module `mlp_weight_ram`:
  - single bank, synchronous write, registered read, `(* ramstyle = "M9K" *)`;
  - instantiated NUM_BANKS times via generate.
- Top level contains the clear FSM, stream pointer, write decode, and rd_valid register.

## Test plan
- Reset then clear: pulse rst for 3 cycles and release. Required: busy=1 for exactly 64 cycles, then 0; then rd_en at addr 0..63 → every lane reads 0, rd_valid 1 cycle after each rd_en.
- Stream load across banks: ld_start bank 0/addr 62, then ld_valid with data 0x1111, 0x2222, 0x3333. Required: bank0[62]=0x1111, bank0[63]=0x2222, bank1[0]=0x3333.
- Global wrap: start at bank 3/addr 63, write 0xABCD then 0x0F0F. Required: bank3[63]=0xABCD, bank0[0]=0x0F0F, one ld_wrap pulse.
- Read-during-write: bank2[5]=0x0005; same cycle write 0x7777 to bank2[5] and rd_en addr 5. Required: lane 2 returns 0x0005; next read returns 0x7777.
- Writes and reads during clear: ld_valid 0x5555 and rd_en at cycle 10 of the clear. Required: ld_ready=0, rd_valid stays 0; after clear, all locations read 0.
- Reset mid-stream: load 5 words, assert rst, then release. Required: clear runs 64 cycles, all memory reads 0, pointer at 0/0 (next ld_valid lands in bank0[0]).
